trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 144 ++++++++++++++
 tb/tb_trap_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// I/O port trap controller: watches Z80 I/O cycles, raises a timed NMI on mapped
// ports, and holds the trap until the handler's RETN releases it.
module trap_ctrl #(
  parameter int unsigned NMI_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic [7:0] addr,
  input  logic       io_direction,
  input  logic       last_isr_untrap,
  input  logic       trap_en,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [7:0] cfg_data,
  output logic       nmi_n,
  output logic       io_block,
  output logic       ignore_next_isr,
  output logic       trap_active,
  output logic [7:0] trap_port,
  output logic       trap_dir,
  output logic [7:0] trap_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NMI     = 2'd1,
    HANDLER = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] NMI_LOAD = 8'(NMI_WIDTH);

  state_t      state_q, state_d;
  // Bit 1 of each synchronizer is the copy the logic is allowed to use.
  logic [1:0]  iorq_sync_q, iorq_sync_d;
  logic [1:0]  m1_sync_q, m1_sync_d;
  logic [1:0]  untrap_sync_q, untrap_sync_d;
  logic        iorq_prev_q, iorq_prev_d;
  logic        untrap_prev_q, untrap_prev_d;
  logic [15:0] trap_map_q, trap_map_d;
  logic [7:0]  nmi_cnt_q, nmi_cnt_d;
  logic [7:0]  trap_port_q, trap_port_d;
  logic        trap_dir_q, trap_dir_d;
  logic [7:0]  trap_count_q, trap_count_d;
  logic        io_block_q, io_block_d;

  logic io_start;
  logic untrap_rise;
  logic trap_hit;

  always_comb begin
    iorq_sync_d   = {iorq_sync_q[0], iorq_n};
    m1_sync_d     = {m1_sync_q[0], m1_n};
    untrap_sync_d = {untrap_sync_q[0], last_isr_untrap};
    iorq_prev_d   = iorq_sync_q[1];
    untrap_prev_d = untrap_sync_q[1];

    // Interrupt-acknowledge cycles (M1 low) never count as I/O starts.
    io_start    = iorq_prev_q & ~iorq_sync_q[1] & m1_sync_q[1];
    untrap_rise = untrap_sync_q[1] & ~untrap_prev_q;
    trap_hit    = trap_map_q[addr[7:4]];

    state_d      = state_q;
    nmi_cnt_d    = nmi_cnt_q;
    trap_port_d  = trap_port_q;
    trap_dir_d   = trap_dir_q;
    trap_count_d = trap_count_q;
    io_block_d   = io_block_q;
    trap_map_d   = trap_map_q;

    if (cfg_we) begin
      if (cfg_sel) trap_map_d[15:8] = cfg_data;
      else         trap_map_d[7:0]  = cfg_data;
    end

    if (iorq_sync_q[1]) io_block_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Decision reads trap_map_q, so a same-edge cfg write is not yet visible.
        if (io_start && trap_en && trap_hit) begin
          state_d     = NMI;
          nmi_cnt_d   = NMI_LOAD;
          trap_port_d = addr;
          trap_dir_d  = io_direction;
          io_block_d  = 1'b1;
          if (trap_count_q != 8'hFF) trap_count_d = trap_count_q + 8'd1;
        end
      end
      NMI: begin
        if (nmi_cnt_q <= 8'd1) state_d = HANDLER;
        else                   nmi_cnt_d = nmi_cnt_q - 8'd1;
      end
      HANDLER: begin
        if (untrap_rise) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    nmi_n           = (state_q != NMI);
    ignore_next_isr = (state_q != HANDLER);
    trap_active     = (state_q == NMI) || (state_q == HANDLER);
    io_block        = io_block_q;
    trap_port       = trap_port_q;
    trap_dir        = trap_dir_q;
    trap_count      = trap_count_q;
    dbg_state       = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      iorq_sync_q   <= 2'b11;
      m1_sync_q     <= 2'b11;
      untrap_sync_q <= 2'b00;
      iorq_prev_q   <= 1'b1;
      untrap_prev_q <= 1'b0;
      trap_map_q    <= 16'h0000;
      nmi_cnt_q     <= 8'd0;
      trap_port_q   <= 8'h00;
      trap_dir_q    <= 1'b0;
      trap_count_q  <= 8'd0;
      io_block_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      iorq_sync_q   <= iorq_sync_d;
      m1_sync_q     <= m1_sync_d;
      untrap_sync_q <= untrap_sync_d;
      iorq_prev_q   <= iorq_prev_d;
      untrap_prev_q <= untrap_prev_d;
      trap_map_q    <= trap_map_d;
      nmi_cnt_q     <= nmi_cnt_d;
      trap_port_q   <= trap_port_d;
      trap_dir_q    <= trap_dir_d;
      trap_count_q  <= trap_count_d;
      io_block_q    <= io_block_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: driver tasks issue Z80 I/O cycles, a model predicts traps,
// and a monitor checks every NMI pulse against the expected queue.
module tb_trap_ctrl;
  localparam int NMI_WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iorq_n = 1'b1;
  logic       m1_n = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       io_direction = 1'b0;
  logic       last_isr_untrap = 1'b0;
  logic       trap_en = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       nmi_n, io_block, ignore_next_isr, trap_active, trap_dir;
  logic [7:0] trap_port, trap_count;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  // Expected trap record: {dir, port, count}
  logic [16:0] exp_q[$];
  logic        abort_pulse = 1'b0;
  logic [15:0] model_map = 16'h0000;
  int          model_count = 0;

  trap_ctrl #(.NMI_WIDTH(NMI_WIDTH)) dut (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .addr(addr),
    .io_direction(io_direction), .last_isr_untrap(last_isr_untrap),
    .trap_en(trap_en), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .nmi_n(nmi_n), .io_block(io_block), .ignore_next_isr(ignore_next_isr),
    .trap_active(trap_active), .trap_port(trap_port), .trap_dir(trap_dir),
    .trap_count(trap_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected record per NMI falling edge, checks pulse width.
  initial begin : monitor
    logic prev_nmi;
    int   width;
    logic [16:0] e;
    prev_nmi = 1'b1;
    width = 0;
    forever begin
      @(negedge clk);
      if (prev_nmi && !nmi_n && !reset) begin
        width = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trap port=0x%0h dir=%0d expected=no_trap", trap_port, trap_dir);
        end else begin
          e = exp_q.pop_front();
          check("trap_port", trap_port, e[15:8]);
          check("trap_dir", trap_dir, e[16]);
          check("trap_count", trap_count, e[7:0]);
        end
      end
      if (!nmi_n) width++;
      if (!prev_nmi && nmi_n) begin
        if (!abort_pulse) check("nmi_width", width, NMI_WIDTH);
        abort_pulse = 1'b0;
      end
      prev_nmi = nmi_n;
    end
  end

  task automatic cfg_write(input logic sel, input logic [7:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (sel) model_map[15:8] = data;
    else     model_map[7:0]  = data;
  endtask

  // One I/O cycle; optional cfg write lands on the same edge the trap is decided.
  task automatic io_cycle(input logic [7:0] port, input logic dir, input logic m1_low,
                          input logic in_handler, input logic do_cfg, input logic sel,
                          input logic [7:0] data, output logic took);
    took = !in_handler && trap_en && !m1_low && model_map[port[7:4]];
    @(negedge clk);
    addr = port; io_direction = dir; m1_n = ~m1_low; iorq_n = 1'b0;
    if (took) begin
      if (model_count < 255) model_count++;
      exp_q.push_back({dir, port, 8'(model_count)});
    end
    repeat (2) @(negedge clk);
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    end
    @(negedge clk);
    cfg_we = 1'b0;
    if (do_cfg) begin
      if (sel) model_map[15:8] = data;
      else     model_map[7:0]  = data;
    end
    @(negedge clk);
    check("io_block_during", io_block, took);
    iorq_n = 1'b1;
    repeat (4) @(negedge clk);
    check("io_block_after", io_block, 1'b0);
    m1_n = 1'b1;
  endtask

  task automatic handler_exit(input int n_io);
    logic t;
    repeat (NMI_WIDTH + 4) @(negedge clk);
    check("nmi_released", nmi_n, 1'b1);
    check("ignore_in_handler", ignore_next_isr, 1'b0);
    check("active_in_handler", trap_active, 1'b1);
    trap_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < n_io; i++)
      io_cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
               1'b0, 1'b0, 8'h00, t);
    @(negedge clk);
    last_isr_untrap = 1'b1;
    repeat (2) @(negedge clk);
    check("ignore_before_release", ignore_next_isr, 1'b0);
    @(negedge clk);
    check("ignore_release", ignore_next_isr, 1'b1);
    check("active_release", trap_active, 1'b0);
    last_isr_untrap = 1'b0;
    repeat (4) @(negedge clk);
    check("active_idle", trap_active, 1'b0);
  endtask

  initial begin : driver
    logic took;
    logic [7:0] port;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_nmi_n", nmi_n, 1'b1);
    check("rst_io_block", io_block, 1'b0);
    check("rst_ignore", ignore_next_isr, 1'b1);
    check("rst_active", trap_active, 1'b0);
    check("rst_port", trap_port, 8'h00);
    check("rst_dir", trap_dir, 1'b0);
    check("rst_count", trap_count, 8'h00);

    // Basic OUT trap, handler access passes, then release.
    cfg_write(1'b0, 8'h01);
    cfg_write(1'b1, 8'h00);
    trap_en = 1'b1;
    io_cycle(8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, took);
    check("basic_took", took, 1'b1);
    repeat (NMI_WIDTH + 4) @(negedge clk);
    io_cycle(8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, took);
    handler_exit(0);
    trap_en = 1'b1;

    // Unmapped IN, then interrupt acknowledge on a mapped port.
    io_cycle(8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, took);
    check("unmapped_count", trap_count, 8'(model_count));
    io_cycle(8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, took);
    check("iack_count", trap_count, 8'(model_count));

    // Same-edge cfg write: decision uses the old map.
    io_cycle(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, took);
    handler_exit(1);
    trap_en = 1'b1;
    io_cycle(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, took);
    io_cycle(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, took);
    io_cycle(8'h1A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, took);
    if (took) handler_exit(0);
    trap_en = 1'b0;
    io_cycle(8'h1A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, took);
    check("disabled_count", trap_count, 8'(model_count));

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      trap_en = ($urandom_range(0, 4) != 0);
      port = 8'($urandom_range(0, 255));
      io_cycle(port, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'b0,
               ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), took);
      if (took) handler_exit($urandom_range(0, 2));
      check("rand_count", trap_count, 8'(model_count));
    end

    // Reset during the NMI pulse.
    cfg_write(1'b0, 8'h01);
    trap_en = 1'b1;
    @(negedge clk);
    addr = 8'h05; io_direction = 1'b1; m1_n = 1'b1; iorq_n = 1'b0;
    if (model_count < 255) model_count++;
    exp_q.push_back({1'b1, 8'h05, 8'(model_count)});
    repeat (5) @(negedge clk);
    check("pre_reset_nmi", nmi_n, 1'b0);
    abort_pulse = 1'b1;
    reset = 1'b1;
    iorq_n = 1'b1;
    @(negedge clk);
    check("mid_rst_nmi_n", nmi_n, 1'b1);
    check("mid_rst_count", trap_count, 8'h00);
    check("mid_rst_port", trap_port, 8'h00);
    check("mid_rst_io_block", io_block, 1'b0);
    check("mid_rst_active", trap_active, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_map = 16'h0000;
    model_count = 0;
    io_cycle(8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, took);
    check("map_cleared_count", trap_count, 8'h00);

    // Saturation of the trap counter.
    cfg_write(1'b0, 8'h01);
    for (int n = 0; n < 300; n++) begin
      trap_en = 1'b1;
      io_cycle(8'h05, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, took);
      if (took) handler_exit(0);
    end
    check("sat_count", trap_count, 8'd255);

    repeat (10) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
